// File: rtl/ika9958_pkg.sv
// Shared types and timing constants for the ika9958 sync path.
// Build option IKA9958_CSYNC_DEGLITCH_EN is consumed by ika9958_csync_pulse_meas.
package ika9958_pkg;

    typedef enum logic [1:0] {
        CSS_IDLE = 2'd0,
        CSS_HUNT = 2'd1,
        CSS_LOCK = 2'd2
    } css_state_e;

    typedef enum logic [2:0] {
        PC_GLITCH = 3'd0,
        PC_EQ     = 3'd1,
        PC_HS     = 3'd2,
        PC_BROAD  = 3'd3,
        PC_ERR    = 3'd4
    } pulse_class_e;

    localparam int unsigned LINE_NOM   = 342;
    localparam int unsigned MIN_W      = 4;
    localparam int unsigned EQ_MAX     = 18;
    localparam int unsigned HS_MAX     = 40;
    localparam int unsigned BROAD_MIN  = 80;
    localparam int unsigned HALF_LO    = 150;
    localparam int unsigned HALF_HI    = 192;
    localparam int unsigned LINE_TOL   = 4;
    localparam int unsigned LOCK_LINES = 8;
    localparam int unsigned HRST_W     = 2;
    localparam int unsigned VRST_W     = 342;

    localparam int unsigned LW_W     = 8;
    localparam int unsigned PC_W     = 10;
    localparam int unsigned BC_W     = 2;
    localparam int unsigned STREAK_W = $clog2(LOCK_LINES + 1);
    localparam int unsigned HCNT_W   = $clog2(HRST_W + 1);
    localparam int unsigned VCNT_W   = $clog2(VRST_W + 1);

    // Width-to-class mapping of a completed low pulse.
    function automatic pulse_class_e classify_pulse(input logic [LW_W-1:0] w);
        pulse_class_e c;
        if (w < LW_W'(MIN_W))          c = PC_GLITCH;
        else if (w <= LW_W'(EQ_MAX))   c = PC_EQ;
        else if (w <= LW_W'(HS_MAX))   c = PC_HS;
        else if (w >= LW_W'(BROAD_MIN)) c = PC_BROAD;
        else                           c = PC_ERR;
        return c;
    endfunction

endpackage

// File: rtl/ika9958_csync_pulse_meas.sv
// Sync-pin front end: synchronizer, optional majority deglitch
// (IKA9958_CSYNC_DEGLITCH_EN), low-pulse width counter and classification.
module ika9958_csync_pulse_meas
    import ika9958_pkg::*;
(
    input  logic         phiA,
    input  logic         RST_async_n,
    input  logic         phiL_NCEN,
    input  logic         i_CSYNC_n,
    output logic         qual_c,
    output logic         pend_c,
    output pulse_class_e pclass_c
);

    localparam logic [LW_W-1:0] LW_MAX = '1;

    logic            sync1_q;
    logic            sync2_q;
    logic            s_n;
    logic [LW_W-1:0] lw_q;
    logic [LW_W-1:0] lw_d;

    always_ff @(posedge phiA or negedge RST_async_n) begin
        if (!RST_async_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            lw_q    <= '0;
        end else if (phiL_NCEN) begin
            sync1_q <= i_CSYNC_n;
            sync2_q <= sync1_q;
            lw_q    <= lw_d;
        end
    end

`ifdef IKA9958_CSYNC_DEGLITCH_EN
    logic tap1_q;
    logic tap2_q;

    always_ff @(posedge phiA or negedge RST_async_n) begin
        if (!RST_async_n) begin
            tap1_q <= 1'b1;
            tap2_q <= 1'b1;
        end else if (phiL_NCEN) begin
            tap1_q <= sync2_q;
            tap2_q <= tap1_q;
        end
    end

    assign s_n = (sync2_q & tap1_q) | (sync2_q & tap2_q) | (tap1_q & tap2_q);
`else
    assign s_n = sync2_q;
`endif

    // lw still holds the full width on the first high tick, so the pulse is classified there.
    always_comb begin
        lw_d = '0;
        if (!s_n) begin
            lw_d = (lw_q == LW_MAX) ? lw_q : lw_q + 1'b1;
        end
        qual_c   = !s_n && (lw_q == LW_W'(MIN_W - 1));
        pend_c   = s_n && (lw_q != '0);
        pclass_c = classify_pulse(lw_q);
    end

endmodule

// File: rtl/ika9958_csync_sep.sv
// Composite-sync separator: regenerates HRST/VRST strobes, field, line length and lock
// from an external composite sync. Optional input deglitch via IKA9958_CSYNC_DEGLITCH_EN.
module ika9958_csync_sep
    import ika9958_pkg::*;
(
    input  logic             phiA,
    input  logic             RST_async_n,
    input  logic             phiL_NCEN,
    input  logic             i_CSYNC_n,
    output logic             o_HRST_n,
    output logic             o_VRST_n,
    output logic             o_FIELD,
    output logic             o_LOCKED,
    output logic [PC_W-1:0]  o_LINE_LEN
);

    localparam logic [PC_W-1:0] PC_MAX = '1;

    logic         qual_c;
    logic         pend_c;
    pulse_class_e pclass_c;

    ika9958_csync_pulse_meas u_meas (
        .phiA        (phiA),
        .RST_async_n (RST_async_n),
        .phiL_NCEN   (phiL_NCEN),
        .i_CSYNC_n   (i_CSYNC_n),
        .qual_c      (qual_c),
        .pend_c      (pend_c),
        .pclass_c    (pclass_c)
    );

    css_state_e          state_q,    state_d;
    logic [PC_W-1:0]     pc_q,       pc_d;
    logic [STREAK_W-1:0] streak_q,   streak_d;
    logic [BC_W-1:0]     bc_q,       bc_d;
    logic [HCNT_W-1:0]   hcnt_q,     hcnt_d;
    logic [VCNT_W-1:0]   vcnt_q,     vcnt_d;
    logic [PC_W-1:0]     line_len_q, line_len_d;
    logic                half_q,     half_d;
    logic                fieldq_q,   fieldq_d;
    logic                field_q,    field_d;
    logic                hrst_n_q,   hrst_n_d;
    logic                vrst_n_q,   vrst_n_d;
    logic                locked_q,   locked_d;
    logic                line_start;
    logic                in_tol;
    logic                err;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        streak_d   = streak_q;
        bc_d       = bc_q;
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        line_len_d = line_len_q;
        half_d     = half_q;
        fieldq_d   = fieldq_q;
        field_d    = field_q;

        line_start = qual_c && ((pc_q >= PC_W'(HALF_HI)) || (state_q == CSS_IDLE));
        in_tol     = (pc_q >= PC_W'(LINE_NOM - LINE_TOL)) && (pc_q <= PC_W'(LINE_NOM + LINE_TOL));
        err        = pend_c && (pclass_c == PC_ERR);

        if (pc_q != PC_MAX) pc_d = pc_q + 1'b1;
        if (hcnt_q != '0)   hcnt_d = hcnt_q - 1'b1;
        if (vcnt_q != '0)   vcnt_d = vcnt_q - 1'b1;

        if (qual_c) half_d = (pc_q >= PC_W'(HALF_LO)) && (pc_q < PC_W'(HALF_HI));

        if (line_start) begin
            pc_d   = PC_W'(1);
            hcnt_d = HCNT_W'(HRST_W);
            if (state_q != CSS_IDLE) line_len_d = pc_q;
        end

        // Lock tracking on line-start distances and error pulses.
        case (state_q)
            CSS_IDLE: begin
                if (line_start) begin
                    state_d  = CSS_HUNT;
                    streak_d = '0;
                end
            end
            CSS_HUNT: begin
                if (line_start) begin
                    if (in_tol) begin
                        streak_d = streak_q + 1'b1;
                        if (streak_q == STREAK_W'(LOCK_LINES - 1)) state_d = CSS_LOCK;
                    end else begin
                        streak_d = '0;
                    end
                end
                if (err) streak_d = '0;
            end
            CSS_LOCK: begin
                if ((line_start && !in_tol) || err) begin
                    state_d  = CSS_HUNT;
                    streak_d = '0;
                end
            end
            default: state_d = CSS_IDLE;
        endcase

        if ((pc_q == PC_MAX) && !line_start) begin
            state_d  = CSS_IDLE;
            streak_d = '0;
        end

        // Broad-pulse counting drives field capture and the vertical strobe.
        if (pend_c) begin
            case (pclass_c)
                PC_BROAD: begin
                    if (bc_q != '1) bc_d = bc_q + 1'b1;
                    if (bc_q == BC_W'(0)) fieldq_d = half_q;
                    if (bc_q == BC_W'(2)) begin
                        field_d = fieldq_q;
                        vcnt_d  = VCNT_W'(VRST_W);
                    end
                end
                PC_HS:   bc_d = '0;
                default: ;
            endcase
        end

        hrst_n_d = (hcnt_d == '0);
        vrst_n_d = (vcnt_d == '0);
        locked_d = (state_q == CSS_LOCK);
    end

    always_ff @(posedge phiA or negedge RST_async_n) begin
        if (!RST_async_n) begin
            state_q    <= CSS_IDLE;
            pc_q       <= '0;
            streak_q   <= '0;
            bc_q       <= '0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            line_len_q <= '0;
            half_q     <= 1'b0;
            fieldq_q   <= 1'b0;
            field_q    <= 1'b0;
            hrst_n_q   <= 1'b1;
            vrst_n_q   <= 1'b1;
            locked_q   <= 1'b0;
        end else if (phiL_NCEN) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            streak_q   <= streak_d;
            bc_q       <= bc_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            line_len_q <= line_len_d;
            half_q     <= half_d;
            fieldq_q   <= fieldq_d;
            field_q    <= field_d;
            hrst_n_q   <= hrst_n_d;
            vrst_n_q   <= vrst_n_d;
            locked_q   <= locked_d;
        end
    end

    assign o_HRST_n   = hrst_n_q;
    assign o_VRST_n   = vrst_n_q;
    assign o_FIELD    = field_q;
    assign o_LOCKED   = locked_q;
    assign o_LINE_LEN = line_len_q;

endmodule

// File: tb/tb_ika9958_csync_sep.sv
// Directed bench for ika9958_csync_sep: NTSC lines, vertical intervals, glitch/error
// pulses, off-nominal lines, sync loss and mid-pulse reset.
module tb_ika9958_csync_sep;

    logic       phiA = 1'b0;
    logic       RST_async_n;
    logic       phiL_NCEN;
    logic       i_CSYNC_n;
    logic       o_HRST_n;
    logic       o_VRST_n;
    logic       o_FIELD;
    logic       o_LOCKED;
    logic [9:0] o_LINE_LEN;

    ika9958_csync_sep dut (
        .phiA        (phiA),
        .RST_async_n (RST_async_n),
        .phiL_NCEN   (phiL_NCEN),
        .i_CSYNC_n   (i_CSYNC_n),
        .o_HRST_n    (o_HRST_n),
        .o_VRST_n    (o_VRST_n),
        .o_FIELD     (o_FIELD),
        .o_LOCKED    (o_LOCKED),
        .o_LINE_LEN  (o_LINE_LEN)
    );

    always #5 phiA = ~phiA;

    int   n_chk = 0;
    int   n_fail = 0;
    int   g = 0;
    int   hstarts = 0;
    int   vlow = 0;
    int   vfirst = -1;
    int   hfirst = -1;
    int   hlow = 0;
    logic hprev = 1'b1;
    logic vprev = 1'b1;
    bit   lk_seen = 1'b0;
    bit   lk_drop = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One enabled clock with output monitoring sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge phiA);
        #1;
        g++;
        if (!o_HRST_n && hprev) hstarts++;
        hprev = o_HRST_n;
        if (!o_VRST_n) begin
            vlow++;
            if (vprev && vfirst < 0) vfirst = g;
        end
        vprev = o_VRST_n;
        if (o_LOCKED)  lk_seen = 1'b1;
        if (!o_LOCKED) lk_drop = 1'b1;
    endtask

    // Low pulse of width w in a period per, optional extra low glitch at gpos of width gw.
    task automatic pulse(input int w, input int per, input int gpos, input int gw);
        hfirst = -1;
        hlow   = 0;
        for (int i = 0; i < per; i++) begin
            i_CSYNC_n = ((i < w) || (gw > 0 && i >= gpos && i < gpos + gw)) ? 1'b0 : 1'b1;
            tick();
            if (!o_HRST_n) begin
                hlow++;
                if (hfirst < 0) hfirst = i + 1;
            end
        end
    endtask

    // 6 EQ / 6 broad / 6 EQ at half-line spacing, optionally shifted by half a line.
    task automatic vint(input bit offset, input int exp_field);
        int gs;
        gs = 0;
        if (offset) pulse(25, 171, 0, 0);
        hstarts = 0;
        vlow    = 0;
        vfirst  = -1;
        lk_drop = 1'b0;
        for (int j = 0; j < 18; j++) begin
            if (j == 8) gs = g;
            pulse((j >= 6 && j < 12) ? 145 : 12, (offset && j == 17) ? 342 : 171, 0, 0);
        end
        chk("vrst_start",   vfirst, gs + 148);
        chk("vrst_width",   vlow, 342);
        chk("v_hrst_count", hstarts, 9);
        chk("v_field",      32'(o_FIELD), exp_field);
        chk("v_lock_held",  32'(lk_drop), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int gs;
        RST_async_n = 1'b0;
        phiL_NCEN   = 1'b1;
        i_CSYNC_n   = 1'b1;
        repeat (3) @(posedge phiA);
        #1;
        chk("rst_hrst", 32'(o_HRST_n), 1);
        chk("rst_vrst", 32'(o_VRST_n), 1);
        chk("rst_field", 32'(o_FIELD), 0);
        chk("rst_lock", 32'(o_LOCKED), 0);
        chk("rst_len", 32'(o_LINE_LEN), 0);
        RST_async_n = 1'b1;

        for (int i = 1; i <= 10; i++) begin
            pulse(25, 342, 0, 0);
            if (i == 1) begin
                chk("hrst_lat1", hfirst, 6);
                chk("hrst_w1", hlow, 2);
                chk("len_idle", 32'(o_LINE_LEN), 0);
            end
            if (i == 2)  chk("len_line2", 32'(o_LINE_LEN), 342);
            if (i == 8)  chk("lock_line8", 32'(o_LOCKED), 0);
            if (i == 9)  chk("lock_line9", 32'(o_LOCKED), 1);
            if (i == 10) begin
                chk("hrst_lat10", hfirst, 6);
                chk("hrst_w10", hlow, 2);
            end
        end

        // Input held low while ticks are disabled must not register.
        bad = 0;
        phiL_NCEN = 1'b0;
        i_CSYNC_n = 1'b0;
        repeat (30) begin
            @(posedge phiA);
            #1;
            if (!o_HRST_n) bad++;
        end
        i_CSYNC_n = 1'b1;
        @(posedge phiA);
        #1;
        phiL_NCEN = 1'b1;
        chk("ncen_hold", bad, 0);
        pulse(25, 342, 0, 0);
        chk("ncen_len", 32'(o_LINE_LEN), 342);

        vint(1'b0, 0);
        pulse(25, 342, 0, 0);
        vint(1'b1, 1);
        pulse(25, 342, 0, 0);
        chk("post_v_len", 32'(o_LINE_LEN), 342);

        pulse(25, 342, 250, 3);
        chk("glitch_hrst", hlow, 2);
        chk("glitch_lock", 32'(o_LOCKED), 1);
        pulse(25, 342, 0, 0);
        chk("glitch_len", 32'(o_LINE_LEN), 342);

        pulse(60, 342, 0, 0);
        chk("err_unlock", 32'(o_LOCKED), 0);
        for (int i = 1; i <= 8; i++) begin
            pulse(25, 342, 0, 0);
            if (i == 7) chk("relock7", 32'(o_LOCKED), 0);
            if (i == 8) chk("relock8", 32'(o_LOCKED), 1);
        end

        pulse(25, 348, 0, 0);
        pulse(25, 348, 0, 0);
        lk_seen = 1'b0;
        for (int i = 0; i < 8; i++) pulse(25, 348, 0, 0);
        chk("long_lock", 32'(lk_seen), 0);
        chk("long_len", 32'(o_LINE_LEN), 348);

        pulse(25, 1200, 0, 0);
        pulse(25, 342, 0, 0);
        chk("idle_hrst", hfirst, 6);
        chk("idle_len", 32'(o_LINE_LEN), 348);
        pulse(25, 342, 0, 0);
        chk("rehunt_len", 32'(o_LINE_LEN), 342);

        // Two broads, then reset in the middle of the third.
        pulse(145, 171, 0, 0);
        pulse(145, 171, 0, 0);
        for (int i = 0; i < 60; i++) begin
            i_CSYNC_n = 1'b0;
            tick();
        end
        #2;
        RST_async_n = 1'b0;
        #1;
        chk("mid_rst_field", 32'(o_FIELD), 0);
        chk("mid_rst_len", 32'(o_LINE_LEN), 0);
        chk("mid_rst_lock", 32'(o_LOCKED), 0);
        chk("mid_rst_hrst", 32'(o_HRST_n), 1);
        chk("mid_rst_vrst", 32'(o_VRST_n), 1);
        for (int i = 0; i < 85; i++) tick();
        i_CSYNC_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        RST_async_n = 1'b1;
        vlow   = 0;
        vfirst = -1;
        pulse(145, 171, 0, 0);
        pulse(145, 171, 0, 0);
        chk("no_vrst_2broad", vlow, 0);
        gs = g;
        pulse(145, 171, 0, 0);
        chk("rst_vrst_start", vfirst, gs + 148);
        pulse(25, 342, 0, 0);
        chk("rst_vrst_width", vlow, 342);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ika9958_csync_sep.md
Name: ika9958_csync_sep

Overview:
- Composite-sync separator for external-sync (genlock/superimpose) operation.
- Takes an external active-low composite sync, classifies each low pulse (equalizing, hsync, broad/vsync) and regenerates the low-active HRST and VRST strobes expected by the screen-timing block's reset inputs.
- Also recovers field parity, last line length and a lock indication.
- Sits between the external sync pin and the screen-timing HRST/VRST inputs; counts on the same dot-rate tick (342 ticks/line).

Parameters:
- MIN_W, 4: low pulses shorter than this (ticks) are glitches.
- EQ_MAX, 18: max width of an equalizing pulse.
- HS_MAX, 40: max width of an hsync pulse.
- BROAD_MIN, 80: min width of a broad (vsync serration) pulse.
- HALF_LO, 150: low bound of the half-line distance window.
- HALF_HI, 192: high bound of the half-line distance window.
- LINE_NOM, 342: nominal line length in ticks.
- LINE_TOL, 4: accepted line-length deviation (±).
- LOCK_LINES, 8: consecutive good lines needed to lock.
- HRST_W, 2: o_HRST_n low width (ticks).
- VRST_W, 342: o_VRST_n low width (ticks).

Ports:
- phiA, input, 1: master clock.
- RST_async_n, input, 1: asynchronous active-low reset.
- phiL_NCEN, input, 1: tick enable; all state advances only on phiA posedge with phiL_NCEN=1.
- i_CSYNC_n, input, 1: external composite sync, asynchronous.
- o_HRST_n, output, 1: regenerated horizontal reset strobe, active low.
- o_VRST_n, output, 1: regenerated vertical reset strobe, active low.
- o_FIELD, output, 1: recovered field; 0 = primary, 1 = secondary.
- o_LOCKED, output, 1: horizontal lock.
- o_LINE_LEN, output, 10: last measured line length (ticks).

Behaviour:
- Reset values: o_HRST_n=1, o_VRST_n=1, o_FIELD=0, o_LOCKED=0, o_LINE_LEN=0. All counters are 0, the FSM is IDLE, and the synchronizer flops are 1.
- Input path: 2-flop synchronizer, both flops clocked on enabled ticks, producing s_n.
- Pulse-width counter lw, 8 bits, saturates at 255:
  - counts while s_n=0;
  - cleared one tick after s_n returns to 1.
- Line-period counter pc, 10 bits, saturates at 1023:
  - increments every tick;
  - reloads to 1 on the tick an HRST is issued.
- Qualification: on the tick lw becomes MIN_W, distance d = pc.
  - d >= HALF_HI, or FSM=IDLE: line-start pulse.
    - Drive o_HRST_n low for HRST_W ticks starting on the next tick.
    - Load o_LINE_LEN <= d unless FSM=IDLE.
    - Reload pc.
  - HALF_LO <= d < HALF_HI: half-line pulse; no HRST.
  - d < HALF_LO: spurious; ignored.
  - HRST latency is MIN_W+2 ticks from the i_CSYNC_n falling edge.
- Classification at pulse end (first tick s_n=1, width W = lw):
  - W < MIN_W: glitch; no effect on any state.
  - MIN_W..EQ_MAX: EQ.
  - EQ_MAX+1..HS_MAX: HS.
  - >= BROAD_MIN: BROAD.
  - HS_MAX+1..BROAD_MIN-1: ERR; clears the lock streak.
- Broad counter bc, 2 bits, saturating:
  - BROAD increments it;
  - HS clears it;
  - EQ leaves it unchanged.
- Field capture: on the first BROAD (bc 0→1), fieldq = 1 if that pulse's d fell in the half-line window, else 0.
- Vertical strobe: when bc goes 2→3:
  - o_FIELD <= fieldq;
  - o_VRST_n is driven low for VRST_W ticks.
  - A further bc 2→3 while o_VRST_n is low restarts the VRST_W count.
- FSM:
  - IDLE: at reset, or whenever pc saturates at 1023. Any line-start → HUNT (streak = 0).
  - HUNT: each line-start with |d−LINE_NOM| <= LINE_TOL increments the streak. An out-of-tolerance d, or ERR, sets streak = 0. Streak reaching LOCK_LINES → LOCK.
  - LOCK: o_LOCKED=1. An out-of-tolerance line-start or ERR → HUNT (streak = 0, o_LOCKED=0). pc saturation → IDLE.
- o_LOCKED is registered: it asserts one tick after entry to LOCK and deasserts one tick after exit.
- Simultaneous events: a HRST issue and a VRST issue on the same tick are both honoured.
- Mid-pulse reset: returns to the reset values; the pulse in progress is discarded.

Optional Feature:
- Macro: IKA9958_CSYNC_DEGLITCH_EN.
- Defined: a 3-tap majority filter (enabled ticks) sits after the synchronizer. s_n is the majority value, adding 1 tick of input latency; all latencies above grow by 1.
- Undefined: s_n is the synchronizer output directly.

Decomposition:
- Shared package ika9958_pkg holds:
  - the FSM enum (CSS_IDLE, CSS_HUNT, CSS_LOCK);
  - the pulse-class enum (PC_GLITCH, PC_EQ, PC_HS, PC_BROAD, PC_ERR);
  - LINE_NOM as a package constant shared with the timing block.
- One natural sub-module: ika9958_csync_pulse_meas (synchronizer, optional deglitch, lw counter, classification).
- The parent holds pc, the FSM, bc, the strobes and lock.

Test Plan:
- Reset, then 10 NTSC lines (low 25 ticks, period 342) → o_HRST_n low 2 ticks, 6 ticks after each falling edge; o_LINE_LEN=342; o_LOCKED=1 after the 8th good line.
- Vertical interval on line-start boundary: 6 EQ (12 wide, half-line spaced), 6 BROAD (145 wide), 6 EQ → o_VRST_n low 342 ticks starting after the 3rd broad ends; o_FIELD=0; HRST only on full-line pulses; lock held.
- Same interval offset by half a line → o_FIELD=1.
- Glitches 3 ticks wide mid-line, and a 60-tick pulse → glitch has no effect; the 60-tick pulse drops o_LOCKED to 0 and relocks after 8 lines.
- Lines of 348 ticks (> LINE_TOL) → o_LOCKED stays 0; o_LINE_LEN=348. Sync removed for 1023 ticks → FSM IDLE; the next edge issues HRST without updating o_LINE_LEN.
- Assert RST_async_n low mid-broad pulse → all outputs return to their reset values immediately; no VRST after release until 3 new broad pulses arrive.
